switch_input_buffer: RTL



---
 rtl/switch_input_buffer_if.sv | 31 +++
 rtl/switch_input_buffer.sv | 85 ++++++++
 2 files changed

// File: rtl/switch_input_buffer_if.sv
// Flit handshake between the input-port register stage, the input buffer
// and the switch allocator/crossbar.
interface switch_input_buffer_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3
);
  logic [FLIT_WIDTH-1:0] FLIT_in;
  logic                  VALID_in;
  logic                  FWDAUX1_in;
  logic                  BWDAUX1_out_c;
  logic                  BWDAUX2_out_c;
  logic                  BWDAUX3_out_c;
  logic [FLIT_WIDTH-1:0] FLIT_out;
  logic                  VALID_out;
  logic                  TAIL_out;
  logic                  HEAD_out;
  logic                  READY_in;
  logic [DEPTH_LOG2:0]   COUNT;

  modport slave (
    input  FLIT_in, VALID_in, FWDAUX1_in, READY_in,
    output BWDAUX1_out_c, BWDAUX2_out_c, BWDAUX3_out_c,
    output FLIT_out, VALID_out, TAIL_out, HEAD_out, COUNT
  );

  modport master (
    output FLIT_in, VALID_in, FWDAUX1_in, READY_in,
    input  BWDAUX1_out_c, BWDAUX2_out_c, BWDAUX3_out_c,
    input  FLIT_out, VALID_out, TAIL_out, HEAD_out, COUNT
  );
endinterface

// File: rtl/switch_input_buffer.sv
// Per-input-port flit FIFO with stall/drop backpressure and a head-flit
// marker derived from a small packet-boundary FSM on the output side.
module switch_input_buffer #(
  parameter int FLIT_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 3,
  parameter int STALL_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_input_buffer_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] STALL_CNT = (DEPTH_LOG2+1)'(DEPTH - STALL_MARGIN);

  typedef enum logic {S_IDLE, S_IN_PKT} pkt_state_t;

  // Each entry holds {tail, flit}
  logic [FLIT_WIDTH:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  pkt_state_t            state_q;

  logic full, valid_out, head_tail, deq, enq, drop;

  always_comb begin
    full      = (count_q == FULL_CNT);
    valid_out = (count_q != '0);
    head_tail = mem_q[rd_ptr_q][FLIT_WIDTH];
    deq       = valid_out & bus.READY_in & ~rst;
    // A dequeue in the same cycle frees the slot, so a full buffer still accepts
    enq       = bus.VALID_in & (~full | deq) & ~rst;
    drop      = bus.VALID_in & full & ~deq & ~rst;

    wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (deq && !enq) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= {bus.FWDAUX1_in, bus.FLIT_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (deq) begin
      case (state_q)
        S_IDLE:   if (!head_tail) state_q <= S_IN_PKT;
        S_IN_PKT: if (head_tail)  state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.FLIT_out      = mem_q[rd_ptr_q][FLIT_WIDTH-1:0];
  assign bus.TAIL_out      = head_tail;
  assign bus.VALID_out     = valid_out;
  assign bus.HEAD_out      = valid_out & (state_q == S_IDLE);
  assign bus.COUNT         = count_q;
  assign bus.BWDAUX1_out_c = (count_q >= STALL_CNT);
  assign bus.BWDAUX2_out_c = drop;
  assign bus.BWDAUX3_out_c = 1'b0;
endmodule
